// File: rtl/arm_servo_pwm.sv
// Multi-channel hobby-servo PWM generator with per-frame slew limiting.
// Commands set a target angle per channel; the pulse width follows the current angle.
module arm_servo_pwm #(
    parameter int unsigned CH          = 2,
    parameter int unsigned PERIOD_CYC  = 2000000,
    parameter int unsigned MIN_CYC     = 50000,
    parameter int unsigned CYC_PER_DEG = 1111,
    parameter int unsigned MAX_DEG     = 180,
    parameter int unsigned STEP_DEG    = 2,
    parameter int unsigned INIT_DEG    = 90
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_ch,
    input  logic [31:0]   cmd_angle,
    output logic          cmd_err,
    output logic [CH-1:0] pwm,
    output logic [CH-1:0] busy,
    output logic          frame_start
);

    localparam int unsigned CNT_W = $clog2(PERIOD_CYC);
    localparam int unsigned WMAX  = MIN_CYC + MAX_DEG * CYC_PER_DEG;
    localparam int unsigned WID_W = $clog2(WMAX + 1);
    localparam int unsigned DEG_W = 16;

    typedef logic [DEG_W-1:0] deg_t;
    typedef logic [WID_W-1:0] wid_t;

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD_CYC - 1);
    localparam deg_t             MAX_D  = DEG_W'(MAX_DEG);
    localparam deg_t             STEP_D = DEG_W'(STEP_DEG);
    localparam deg_t             INIT_D = DEG_W'(INIT_DEG);
    localparam wid_t             INIT_W = WID_W'(MIN_CYC + INIT_DEG * CYC_PER_DEG);

    function automatic deg_t clamp_deg(input logic [15:0] ip);
        if (ip[15])
            return '0;
        return (ip > MAX_D) ? MAX_D : ip;
    endfunction

    function automatic deg_t slew(input deg_t cur, input deg_t tgt);
        if (tgt > cur)
            return ((tgt - cur) <= STEP_D) ? tgt : cur + STEP_D;
        return ((cur - tgt) <= STEP_D) ? tgt : cur - STEP_D;
    endfunction

    function automatic wid_t width_of(input deg_t d);
        return WID_W'(MIN_CYC) + WID_W'(d) * WID_W'(CYC_PER_DEG);
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;
    deg_t             tgt_q [CH];
    deg_t             tgt_d [CH];
    deg_t             cur_q [CH];
    deg_t             cur_d [CH];
    wid_t             wid_q [CH];
    wid_t             wid_d [CH];
    logic [CH-1:0]    pwm_q, pwm_d, busy_q, busy_d;
    logic             fs_q, fs_d, ready_q, ready_d, err_q, err_d;
    logic             wrap, accept, ch_ok;
    logic             unused_frac;

    assign unused_frac = ^cmd_angle[15:0];

    // run_q holds the counter at 0 for the first post-reset edge so that
    // edge already presents frame_start and the INIT_DEG pulse.
    always_comb begin
        wrap    = run_q && (cnt_q == LAST);
        cnt_d   = (!run_q || wrap) ? '0 : cnt_q + 1'b1;
        accept  = cmd_valid && ready_q;
        ch_ok   = {1'b0, cmd_ch} < 5'(CH);
        fs_d    = (cnt_d == '0);
        ready_d = (cnt_d != LAST);
        err_d   = accept && !ch_ok;
        pwm_d   = '0;
        busy_d  = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            tgt_d[i] = tgt_q[i];
            if (accept && ch_ok && (cmd_ch == 4'(i)))
                tgt_d[i] = clamp_deg(cmd_angle[31:16]);
            cur_d[i]  = wrap ? slew(cur_q[i], tgt_q[i]) : cur_q[i];
            wid_d[i]  = wrap ? width_of(cur_d[i]) : wid_q[i];
            pwm_d[i]  = (CNT_W'(wid_d[i]) > cnt_d);
            busy_d[i] = (cur_d[i] != tgt_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            run_q   <= 1'b0;
            pwm_q   <= '0;
            busy_q  <= '0;
            fs_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < CH; i++) begin
                tgt_q[i] <= INIT_D;
                cur_q[i] <= INIT_D;
                wid_q[i] <= INIT_W;
            end
        end else begin
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            pwm_q   <= pwm_d;
            busy_q  <= busy_d;
            fs_q    <= fs_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < CH; i++) begin
                tgt_q[i] <= tgt_d[i];
                cur_q[i] <= cur_d[i];
                wid_q[i] <= wid_d[i];
            end
        end
    end

    assign pwm         = pwm_q;
    assign busy        = busy_q;
    assign frame_start = fs_q;
    assign cmd_ready   = ready_q;
    assign cmd_err     = err_q;

endmodule

// File: tb/tb_arm_servo_pwm.sv
// Bench for arm_servo_pwm: frame-position model checked every cycle, plus
// directed scenarios whose measured pulse widths are pinned to literal values.
module tb_arm_servo_pwm;

    localparam int CH   = 2;
    localparam int P    = 1000;
    localparam int MINC = 100;
    localparam int CPD  = 4;
    localparam int MAXD = 180;
    localparam int STEP = 10;
    localparam int INIT = 90;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_ch;
    logic [31:0] cmd_angle;
    logic        cmd_err;
    logic [1:0]  pwm;
    logic [1:0]  busy;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    arm_servo_pwm #(
        .CH(CH), .PERIOD_CYC(P), .MIN_CYC(MINC), .CYC_PER_DEG(CPD),
        .MAX_DEG(MAXD), .STEP_DEG(STEP), .INIT_DEG(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_angle(cmd_angle), .cmd_err(cmd_err),
        .pwm(pwm), .busy(busy), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: position in frame + per-channel angles ----------------
    int   m_pos;
    bit   m_run;
    int   m_tgt [CH];
    int   m_cur [CH];
    int   m_wid [CH];
    logic exp_fs, exp_ready, exp_err;
    logic [1:0] exp_pwm, exp_busy;

    function automatic int clamp_deg(input logic [31:0] a);
        int ip;
        ip = int'($signed(a[31:16]));
        if (ip < 0) return 0;
        if (ip > MAXD) return MAXD;
        return ip;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0;
            m_pos = 0;
            for (int i = 0; i < CH; i++) begin
                m_tgt[i] = INIT;
                m_cur[i] = INIT;
                m_wid[i] = MINC + INIT * CPD;
            end
            exp_fs = 0; exp_ready = 0; exp_err = 0; exp_pwm = '0; exp_busy = '0;
        end else begin
            exp_err = 0;
            if (cmd_valid && exp_ready) begin
                if (int'(cmd_ch) < CH) m_tgt[cmd_ch] = clamp_deg(cmd_angle);
                else exp_err = 1;
            end
            if (!m_run) begin
                m_run = 1;
                m_pos = 0;
            end else if (m_pos == P - 1) begin
                m_pos = 0;
                for (int i = 0; i < CH; i++) begin
                    int d;
                    d = m_tgt[i] - m_cur[i];
                    if (d <= STEP && d >= -STEP) m_cur[i] = m_tgt[i];
                    else if (d > 0) m_cur[i] = m_cur[i] + STEP;
                    else m_cur[i] = m_cur[i] - STEP;
                    m_wid[i] = MINC + m_cur[i] * CPD;
                end
            end else begin
                m_pos++;
            end
            exp_fs    = (m_pos == 0);
            exp_ready = (m_pos != P - 1);
            for (int i = 0; i < CH; i++) begin
                exp_pwm[i]  = (m_pos < m_wid[i]);
                exp_busy[i] = (m_cur[i] != m_tgt[i]);
            end
        end
    end

    always @(negedge clk) begin
        chk("frame_start", int'(frame_start), int'(exp_fs));
        chk("cmd_ready", int'(cmd_ready), int'(exp_ready));
        chk("cmd_err", int'(cmd_err), int'(exp_err));
        chk("pwm", int'(pwm), int'(exp_pwm));
        chk("busy", int'(busy), int'(exp_busy));
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_fs();
        int n = 0;
        while (!frame_start && n < P + 5) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start_seen", int'(frame_start), 1);
    endtask

    task automatic measure(output int w0, output int w1);
        w0 = 0;
        w1 = 0;
        wait_fs();
        for (int k = 0; k < P; k++) begin
            if (pwm[0]) w0++;
            if (pwm[1]) w1++;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [3:0] ch, input logic [31:0] ang);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_angle = ang;
        while (!cmd_ready && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy != 2'b00 && n < 25 * P) begin
            @(negedge clk);
            n++;
        end
        chk("idle", int'(busy), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1;
        int n;
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_angle = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_err", int'(cmd_err), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("first_fs", int'(frame_start), 1);
        chk("first_pwm", int'(pwm), 3);
        measure(w0, w1);
        chk("init_w0", w0, 460);
        chk("init_w1", w1, 460);
        chk("period_fs", int'(frame_start), 1);

        // slew 90 -> 45 on ch0
        send(4'd0, 32'h002D_0000);
        chk("slew_busy", int'(busy), 1);
        measure(w0, w1); chk("slew_f1_w0", w0, 420); chk("slew_f1_w1", w1, 460);
        measure(w0, w1); chk("slew_f2_w0", w0, 380);
        measure(w0, w1); chk("slew_f3_w0", w0, 340);
        measure(w0, w1); chk("slew_f4_w0", w0, 300);
        measure(w0, w1); chk("slew_f5_w0", w0, 280); chk("slew_f5_w1", w1, 460);
        chk("slew_done_busy", int'(busy), 0);

        // clamps
        send(4'd0, 32'h00C8_0000);
        wait_idle();
        measure(w0, w1); chk("clamp_hi_w0", w0, 820);
        send(4'd0, 32'hFFFF_0000);
        wait_idle();
        measure(w0, w1); chk("clamp_neg_w0", w0, 100);
        send(4'd0, 32'h005A_8000);
        wait_idle();
        measure(w0, w1); chk("frac_w0", w0, 460); chk("frac_w1", w1, 460);

        // bad channel
        send(4'd2, 32'h0000_0000);
        chk("err_pulse", int'(cmd_err), 1);
        @(negedge clk);
        chk("err_clear", int'(cmd_err), 0);
        chk("err_busy", int'(busy), 0);
        measure(w0, w1); chk("err_w0", w0, 460); chk("err_w1", w1, 460);

        // handshake at the slew-update cycle
        n = 0;
        while (cmd_ready && n < P + 5) begin
            @(negedge clk);
            n++;
        end
        chk("ready_low_last", int'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_ch    = 4'd0;
        cmd_angle = 32'h003C_0000;
        @(negedge clk);
        chk("hs_fs", int'(frame_start), 1);
        chk("hs_ready", int'(cmd_ready), 1);
        chk("hs_not_yet", int'(busy), 0);
        @(negedge clk);
        chk("hs_accepted", int'(busy), 1);
        cmd_valid = 1'b0;
        measure(w0, w1); chk("hs_next_w0", w0, 420);

        // mid-frame reset with ch0 still slewing
        repeat (300) @(negedge clk);
        chk("pre_rst_pwm0", int'(pwm[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pwm", int'(pwm), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_fs", int'(frame_start), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_fs", int'(frame_start), 1);
        measure(w0, w1); chk("rel_w0", w0, 460); chk("rel_w1", w1, 460);
        chk("rel_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_servo_pwm.md
ARM_SERVO_PWM -- requirements
Module: arm_servo_pwm

Interface
REQ-001 SHALL have parameter CH, default 2, number of servo channels (1..16).
REQ-002 SHALL have parameter PERIOD_CYC, default 2000000, frame length in clk cycles (20 ms at 100 MHz).
REQ-003 SHALL have parameter MIN_CYC, default 50000, pulse width at 0 degrees.
REQ-004 SHALL have parameter CYC_PER_DEG, default 1111, added pulse cycles per integer degree.
REQ-005 SHALL have parameter MAX_DEG, default 180, upper angle clamp.
REQ-006 SHALL have parameter STEP_DEG, default 2, maximum angle change per frame (slew limit, >=1).
REQ-007 SHALL have parameter INIT_DEG, default 90, reset angle (<= MAX_DEG).
REQ-008 SHALL have port clk  input  1  single system clock, rising edge.
REQ-009 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-010 SHALL have port cmd_valid  input  1  command strobe.
REQ-011 SHALL have port cmd_ready  output  1  command accept permitted.
REQ-012 SHALL have port cmd_ch  input  4  target channel index.
REQ-013 SHALL have port cmd_angle  input  32  angle in degrees, signed 16.16 fixed point.
REQ-014 SHALL have port cmd_err  output  1  one-cycle pulse on accepted command with cmd_ch >= CH.
REQ-015 SHALL have port pwm  output  CH  servo pulse per channel.
REQ-016 SHALL have port busy  output  CH  channel current angle != target angle.
REQ-017 SHALL have port frame_start  output  1  one-cycle pulse at first cycle of each frame.

Function
REQ-018 SHALL run a frame counter 0..PERIOD_CYC-1, incrementing every cycle and wrapping to 0; frame_start high exactly when counter == 0.
REQ-019 SHALL drive cmd_ready high except in the cycle where counter == PERIOD_CYC-1 (slew update cycle), and low during reset.
REQ-020 SHALL accept a command when cmd_valid && cmd_ready; target register of cmd_ch updated on that clock edge, busy visible next cycle.
REQ-021 SHALL use only cmd_angle[31:16] (integer degrees); fraction bits ignored.
REQ-022 SHALL clamp: bit 31 set -> 0; integer part > MAX_DEG -> MAX_DEG; else integer part.
REQ-023 SHALL, on accepted command with cmd_ch >= CH, leave all targets unchanged and pulse cmd_err for one cycle following the accept edge.
REQ-024 SHALL, when counter == PERIOD_CYC-1, per channel: if |target-current| <= STEP_DEG then current = target, else current moves STEP_DEG toward target.
REQ-025 SHALL latch width[i] = MIN_CYC + current[i]*CYC_PER_DEG at the same edge the counter wraps to 0, using the updated current.
REQ-026 SHALL drive pwm[i] high for exactly width[i] consecutive cycles starting in the frame_start cycle, low for the rest of the frame.
REQ-027 SHALL keep widths constant within a frame; a command mid-frame affects pwm no earlier than the next frame.
REQ-028 SHALL hold busy[i] = (current[i] != target[i]), registered.
REQ-029 SHALL size width arithmetic to hold MIN_CYC + MAX_DEG*CYC_PER_DEG without overflow; legal configurations require this sum < PERIOD_CYC.
REQ-030 SHALL register all outputs (no combinational path from inputs to outputs).

Reset
REQ-031 SHALL, while rst_n low (asserted asynchronously, also mid-frame), force counter 0, pwm 0, busy 0, frame_start 0, cmd_ready 0, cmd_err 0, target = current = INIT_DEG, width = MIN_CYC + INIT_DEG*CYC_PER_DEG.
REQ-032 SHALL, on first clock edge after rst_n release, produce frame_start high and begin INIT_DEG pulses on all channels.

Verification (CH=2, PERIOD_CYC=1000, MIN_CYC=100, CYC_PER_DEG=4, MAX_DEG=180, STEP_DEG=10, INIT_DEG=90)
REQ-033 SHALL verify reset: rst_n low -> all outputs 0; release -> frame_start every 1000 cycles, pwm[1:0] high 460 cycles each frame, busy=0.
REQ-034 SHALL verify slew: cmd ch0 angle 0x002D_0000 -> busy[0]=1; ch0 widths 420,380,340,300,280 on successive frames; busy[0] clears when current=45; ch1 stays 460.
REQ-035 SHALL verify clamp: angle 0x00C8_0000 -> target 180, final width 820; angle 0xFFFF_0000 -> target 0, final width 100; 0x005A_8000 -> 90.
REQ-036 SHALL verify error: cmd_ch=2 accepted -> cmd_err one-cycle pulse, busy and widths unchanged.
REQ-037 SHALL verify handshake boundary: cmd_valid held asserted at counter 999 -> cmd_ready 0, accepted at counter 0; new target slews starting at the following frame boundary.
REQ-038 SHALL verify mid-frame reset: rst_n low at counter 300 with ch0 busy -> pwm, busy immediately 0; after release ch0 restarts at width 460.
